nf10_lpi_announce_rx: RTL and testbench
=======================================

# nf10_lpi_announce_rx

Receive-side counterpart of the NIC sleep-announcement injector. Sits on the RX AXI-Stream path, before the output port lookup. It detects the two-beat low-power-idle (LPI) announcement frame sent by the link partner and removes it from the stream. All other traffic is forwarded unchanged. It also runs a SLEEP → LPI → WAKE timer that models the partner's state, and exposes status and counters.

## Interface
- C_AXIS_DATA_WIDTH, 256: tdata width on both sides; fixed at 256, because field positions are absolute.
- C_AXIS_TUSER_WIDTH, 128: tuser width.
- SLEEP_CYCLES, 3: number of cycles the partner spends in SLEEP after an announcement.
- LPI_CYCLES, 6: number of cycles in LPI.
- WAKE_CYCLES, 4: number of cycles in WAKE.
- CNT_WIDTH, 32: width of the status counters.

Ports:
- axi_aclk  in  1  the single clock.
- axi_resetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  slave stream.
- s_axis_tready  out  1  slave ready.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  master stream.
- m_axis_tready  in  1  master ready.
- partner_state  out  2  0=ACTIVE, 1=SLEEP, 2=LPI, 3=WAKE.
- announce_pulse  out  1  one-cycle pulse when an announcement is dropped.
- announce_count  out  CNT_WIDTH  number of announcements dropped; wraps.
- lpi_violation_count  out  CNT_WIDTH  number of beats accepted while partner_state≠ACTIVE; wraps.

## Operation
- Candidate first beat: s_axis_tdata[111:96]==16'h0c88, tdata[119:112]==8'h45, and tlast=0.
- Magic second beat: tdata[63:16]==48'hdeadbeefbabe and tlast=1.

Stream FSM (states IDLE, HOLD, PASS; reset state IDLE):
- IDLE, beat is a candidate:
  - s_axis_tready=1 and m_axis_tvalid=0.
  - On accept, the whole beat (data, strb, user, last) is captured into the hold register and the FSM goes to HOLD.
- IDLE, beat is not a candidate:
  - Combinational pass-through: m_axis_*=s_axis_*, s_axis_tready=m_axis_tready.
  - On handshake: tlast=1 stays IDLE; tlast=0 goes to PASS.
- HOLD, s_axis_tvalid=0: outputs idle (m_axis_tvalid=0, s_axis_tready=0).
- HOLD, valid beat matches magic:
  - s_axis_tready=1, m_axis_tvalid=0; the beat is dropped, and the hold register is discarded.
  - announce_pulse=1 and the FSM goes to IDLE.
- HOLD, valid beat does not match magic:
  - s_axis_tready=0; m_axis_* is driven from the hold register with m_axis_tvalid=1.
  - On m_axis_tready the FSM goes to PASS; the pending beat then follows by pass-through.
- PASS:
  - Pass-through as in IDLE.
  - The FSM goes to IDLE on a handshake with tlast=1.

Partner timer (states ACTIVE, SLEEP, LPI, WAKE):
- announce_pulse from any state loads SLEEP and clears the phase counter.
- Each phase lasts exactly its parameter value in cycles, then moves to the next phase; WAKE moves to ACTIVE.
- A new announcement during SLEEP, LPI or WAKE restarts SLEEP.
- A *_CYCLES value of 0 skips that phase (it lasts zero cycles).
- lpi_violation_count increments on every accepted s_axis beat while partner_state≠ACTIVE. Dropped announcement beats do not count.

## Timing
- Reset (async assert, sync deassert by the system):
  - FSM=IDLE, timer=ACTIVE, counters=0.
  - announce_pulse=0, m_axis_tvalid=0, s_axis_tready=0.
  - The hold register is cleared.
- Pass-through latency is 0 cycles.
- A held beat is emitted no earlier than the cycle in which its successor is presented.
- announce_pulse is registered: high in the cycle after the second beat is accepted. partner_state becomes SLEEP in the same cycle.
- Output stability: once m_axis_tvalid=1 in HOLD, the data stays stable until m_axis_tready.
- Reset mid-packet: the partial packet and any held beat are discarded. No output beat is produced for them.
- Counters wrap from 2^CNT_WIDTH-1 to 0.

## Structure
- Package nf10_lpi_pkg holds:
  - ANNOUNCE_ETHERTYPE=16'h0c88 and IP_VER_IHL=8'h45.
  - ANNOUNCE_MAGIC=48'hdeadbeefbabe.
  - The field bit positions.
  - The partner_state encoding.
- The package is shared with the transmit-side injector.
- Sub-module nf10_lpi_partner_timer contains the partner FSM and phase counter. Its inputs are announce_pulse and the three cycle parameters; its output is partner_state.

## Test plan
- Announcement with m_axis_tready=1:
  - Drive beat 1 (ethertype 0c88, tlast=0), then beat 2 (magic, tlast=1).
  - Expect: no m_axis beat, announce_count=1, and partner_state sequence SLEEP×3, LPI×6, WAKE×4, then ACTIVE.
- Near-miss:
  - Beat 1 is a candidate; beat 2 has magic 48'hdeadbeefbabf.
  - Expect both beats forwarded in order and bit-exact, and announce_count=0.
- Normal 3-beat packet, ethertype 0800, with m_axis_tready toggling 1/0 every cycle: expect all beats forwarded unchanged with no loss or duplication.
- Candidate beat 1, then 5 idle cycles, then non-magic beat 2 with m_axis_tready=0 for 4 cycles:
  - Expect the held beat to stay stable on m_axis for those 4 cycles.
  - Expect s_axis_tready=0 until the held beat is taken.
- Second announcement while partner_state=LPI: expect a restart to SLEEP. A data packet accepted in SLEEP increments lpi_violation_count by its beat count.
- Reset asserted while in HOLD: expect m_axis_tvalid=0 immediately, and after release the next packet is forwarded cleanly.

Source files
------------

// File: rtl/nf10_lpi_pkg.sv
// Field layout and encodings shared by the LPI announcement injector (TX) and stripper (RX).
package nf10_lpi_pkg;

    localparam logic [15:0] ANNOUNCE_ETHERTYPE = 16'h0c88;
    localparam logic [7:0]  IP_VER_IHL         = 8'h45;
    localparam logic [47:0] ANNOUNCE_MAGIC     = 48'hdeadbeefbabe;

    localparam int ETYPE_LSB = 96;
    localparam int ETYPE_MSB = 111;
    localparam int IPVER_LSB = 112;
    localparam int IPVER_MSB = 119;
    localparam int MAGIC_LSB = 16;
    localparam int MAGIC_MSB = 63;

    typedef enum logic [1:0] {
        PS_ACTIVE = 2'd0,
        PS_SLEEP  = 2'd1,
        PS_LPI    = 2'd2,
        PS_WAKE   = 2'd3
    } partner_state_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_PASS = 2'd2
    } stream_state_e;

    function automatic logic is_candidate(input logic [15:0] etype, input logic [7:0] ipver,
                                          input logic last);
        return (etype == ANNOUNCE_ETHERTYPE) && (ipver == IP_VER_IHL) && !last;
    endfunction

    function automatic logic is_magic(input logic [47:0] magic, input logic last);
        return (magic == ANNOUNCE_MAGIC) && last;
    endfunction

endpackage

// File: rtl/nf10_lpi_partner_timer.sv
// Models the link partner's power state after an announcement: SLEEP -> LPI -> WAKE -> ACTIVE.
module nf10_lpi_partner_timer
    import nf10_lpi_pkg::*;
#(
    parameter int SLEEP_CYCLES = 3,
    parameter int LPI_CYCLES   = 6,
    parameter int WAKE_CYCLES  = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           announce_pulse_i,
    output partner_state_e partner_state_o
);

    partner_state_e state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    phase_len;

    // Zero-length phases are skipped entirely rather than lasting one cycle.
    function automatic partner_state_e settle(input partner_state_e p);
        partner_state_e r;
        r = p;
        if (r == PS_SLEEP && SLEEP_CYCLES == 0) r = PS_LPI;
        if (r == PS_LPI   && LPI_CYCLES   == 0) r = PS_WAKE;
        if (r == PS_WAKE  && WAKE_CYCLES  == 0) r = PS_ACTIVE;
        return r;
    endfunction

    always_comb begin
        phase_len = 32'd0;
        case (state_q)
            PS_SLEEP: phase_len = 32'(SLEEP_CYCLES);
            PS_LPI:   phase_len = 32'(LPI_CYCLES);
            PS_WAKE:  phase_len = 32'(WAKE_CYCLES);
            default:  phase_len = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (announce_pulse_i) begin
            state_d = settle(PS_SLEEP);
            cnt_d   = 32'd0;
        end else if (state_q != PS_ACTIVE) begin
            if (cnt_q + 32'd1 >= phase_len) begin
                cnt_d = 32'd0;
                case (state_q)
                    PS_SLEEP: state_d = settle(PS_LPI);
                    PS_LPI:   state_d = settle(PS_WAKE);
                    default:  state_d = PS_ACTIVE;
                endcase
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PS_ACTIVE;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign partner_state_o = state_q;

endmodule

// File: rtl/nf10_lpi_announce_rx.sv
// RX-path stripper for the partner's two-beat LPI announcement; everything else passes through.
module nf10_lpi_announce_rx
    import nf10_lpi_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int SLEEP_CYCLES       = 3,
    parameter int LPI_CYCLES         = 6,
    parameter int WAKE_CYCLES        = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [1:0]                      partner_state,
    output logic                            announce_pulse,
    output logic [CNT_WIDTH-1:0]            announce_count,
    output logic [CNT_WIDTH-1:0]            lpi_violation_count
);

    stream_state_e                   state_q, state_d;
    logic [C_AXIS_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [C_AXIS_DATA_WIDTH/8-1:0]  hold_strb_q, hold_strb_d;
    logic [C_AXIS_TUSER_WIDTH-1:0]   hold_user_q, hold_user_d;
    logic                            hold_last_q, hold_last_d;
    logic                            hold_viol_q, hold_viol_d;
    logic                            pulse_q;
    logic [CNT_WIDTH-1:0]            ann_cnt_q, viol_cnt_q;
    logic                            drop, viol_inc, out_valid, in_ready;
    logic                            cand, magic;
    partner_state_e                  partner_st;

    assign cand  = is_candidate(s_axis_tdata[ETYPE_MSB:ETYPE_LSB],
                                s_axis_tdata[IPVER_MSB:IPVER_LSB], s_axis_tlast);
    assign magic = is_magic(s_axis_tdata[MAGIC_MSB:MAGIC_LSB], s_axis_tlast);

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_strb_d  = hold_strb_q;
        hold_user_d  = hold_user_q;
        hold_last_d  = hold_last_q;
        hold_viol_d  = hold_viol_q;
        drop         = 1'b0;
        viol_inc     = 1'b0;
        m_axis_tdata = s_axis_tdata;
        m_axis_tstrb = s_axis_tstrb;
        m_axis_tuser = s_axis_tuser;
        m_axis_tlast = s_axis_tlast;
        out_valid    = s_axis_tvalid;
        in_ready     = m_axis_tready;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && cand) begin
                    out_valid   = 1'b0;
                    in_ready    = 1'b1;
                    hold_data_d = s_axis_tdata;
                    hold_strb_d = s_axis_tstrb;
                    hold_user_d = s_axis_tuser;
                    hold_last_d = s_axis_tlast;
                    // Violation status is judged at acceptance, counted only if the beat is released.
                    hold_viol_d = (partner_st != PS_ACTIVE);
                    state_d     = ST_HOLD;
                end else if (s_axis_tvalid && m_axis_tready) begin
                    viol_inc = (partner_st != PS_ACTIVE);
                    state_d  = s_axis_tlast ? ST_IDLE : ST_PASS;
                end
            end
            ST_HOLD: begin
                m_axis_tdata = hold_data_q;
                m_axis_tstrb = hold_strb_q;
                m_axis_tuser = hold_user_q;
                m_axis_tlast = hold_last_q;
                out_valid    = 1'b0;
                in_ready     = 1'b0;
                if (s_axis_tvalid) begin
                    if (magic) begin
                        in_ready    = 1'b1;
                        drop        = 1'b1;
                        hold_data_d = '0;
                        hold_strb_d = '0;
                        hold_user_d = '0;
                        hold_last_d = 1'b0;
                        hold_viol_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_valid = 1'b1;
                        if (m_axis_tready) begin
                            viol_inc = hold_viol_q;
                            state_d  = ST_PASS;
                        end
                    end
                end
            end
            ST_PASS: begin
                if (s_axis_tvalid && m_axis_tready) begin
                    viol_inc = (partner_st != PS_ACTIVE);
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low for as long as reset is held.
    assign m_axis_tvalid = out_valid & axi_resetn;
    assign s_axis_tready = in_ready & axi_resetn;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_strb_q <= '0;
            hold_user_q <= '0;
            hold_last_q <= 1'b0;
            hold_viol_q <= 1'b0;
            pulse_q     <= 1'b0;
            ann_cnt_q   <= '0;
            viol_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_strb_q <= hold_strb_d;
            hold_user_q <= hold_user_d;
            hold_last_q <= hold_last_d;
            hold_viol_q <= hold_viol_d;
            pulse_q     <= drop;
            if (drop)     ann_cnt_q  <= ann_cnt_q + CNT_WIDTH'(1);
            if (viol_inc) viol_cnt_q <= viol_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Fed with the drop strobe so the timer enters SLEEP together with the registered pulse.
    nf10_lpi_partner_timer #(
        .SLEEP_CYCLES (SLEEP_CYCLES),
        .LPI_CYCLES   (LPI_CYCLES),
        .WAKE_CYCLES  (WAKE_CYCLES)
    ) u_timer (
        .clk_i            (axi_aclk),
        .rst_ni           (axi_resetn),
        .announce_pulse_i (drop),
        .partner_state_o  (partner_st)
    );

    assign partner_state       = partner_st;
    assign announce_pulse      = pulse_q;
    assign announce_count      = ann_cnt_q;
    assign lpi_violation_count = viol_cnt_q;

endmodule

// File: tb/tb_nf10_lpi_announce_rx.sv
// Directed bench for the RX announcement stripper and partner-state timer.
module tb_nf10_lpi_announce_rx;

    logic          axi_aclk = 1'b0;
    logic          axi_resetn;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tstrb;
    logic [127:0]  s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tstrb;
    logic [127:0]  m_tuser;
    logic          m_tvalid, m_tlast, m_tready;
    logic [1:0]    partner_state;
    logic          announce_pulse;
    logic [31:0]   announce_count, lpi_violation_count;

    int n_cmp = 0;
    int n_err = 0;
    logic tog_en = 1'b0;

    logic [255:0] mq_d[$];
    logic [31:0]  mq_s[$];
    logic [127:0] mq_u[$];
    logic         mq_l[$];

    always #5 axi_aclk = ~axi_aclk;

    nf10_lpi_announce_rx dut (
        .axi_aclk            (axi_aclk),
        .axi_resetn          (axi_resetn),
        .s_axis_tdata        (s_tdata),
        .s_axis_tstrb        (s_tstrb),
        .s_axis_tuser        (s_tuser),
        .s_axis_tvalid       (s_tvalid),
        .s_axis_tlast        (s_tlast),
        .s_axis_tready       (s_tready),
        .m_axis_tdata        (m_tdata),
        .m_axis_tstrb        (m_tstrb),
        .m_axis_tuser        (m_tuser),
        .m_axis_tvalid       (m_tvalid),
        .m_axis_tlast        (m_tlast),
        .m_axis_tready       (m_tready),
        .partner_state       (partner_state),
        .announce_pulse      (announce_pulse),
        .announce_count      (announce_count),
        .lpi_violation_count (lpi_violation_count)
    );

    // Output beats are logged at the negedge preceding the handshake edge.
    always @(negedge axi_aclk) begin
        if (axi_resetn && m_tvalid && m_tready) begin
            mq_d.push_back(m_tdata);
            mq_s.push_back(m_tstrb);
            mq_u.push_back(m_tuser);
            mq_l.push_back(m_tlast);
        end
    end

    always @(posedge axi_aclk) begin
        if (tog_en) begin
            #1;
            m_tready = ~m_tready;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] et, input logic [7:0] ipv,
                                        input logic [47:0] mg, input logic [31:0] tag);
        logic [255:0] d;
        d = {8{tag}};
        d[111:96]  = et;
        d[119:112] = ipv;
        d[63:16]   = mg;
        return d;
    endfunction

    task automatic clear_q();
        mq_d.delete();
        mq_s.delete();
        mq_u.delete();
        mq_l.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [255:0] d, input logic [127:0] u, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tstrb  = 32'hffff_ffff;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge axi_aclk);
            if (s_tready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 256'd0, 256'd1);
                break;
            end
        end
        @(posedge axi_aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [255:0] d, input logic l);
        if (idx < mq_d.size()) begin
            check({tag, "_data"}, mq_d[idx], d);
            check({tag, "_last"}, {255'd0, mq_l[idx]}, {255'd0, l});
        end else begin
            check({tag, "_missing"}, 256'd0, 256'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] a1, a2, nm2, p1, p2, p3;
        logic [1:0]   exp_ps;
        int           w;

        a1  = mk(16'h0c88, 8'h45, 48'h1111_2222_3333, 32'hA1A1_0001);
        a2  = mk(16'h7777, 8'h00, 48'hdead_beef_babe, 32'hA2A2_0002);
        nm2 = mk(16'h7777, 8'h00, 48'hdead_beef_babf, 32'hB2B2_0003);
        p1  = mk(16'h0800, 8'h45, 48'h0123_4567_89ab, 32'hC1C1_0004);
        p2  = mk(16'h0c88, 8'h45, 48'hdead_beef_babe, 32'hC2C2_0005);
        p3  = mk(16'h0000, 8'h00, 48'hdead_beef_babe, 32'hC3C3_0006);

        axi_resetn = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        m_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("rst_m_tvalid", {255'd0, m_tvalid}, 256'd0);
        check("rst_s_tready", {255'd0, s_tready}, 256'd0);
        check("rst_pulse", {255'd0, announce_pulse}, 256'd0);
        check("rst_pstate", {254'd0, partner_state}, 256'd0);
        check("rst_ann_cnt", {224'd0, announce_count}, 256'd0);
        check("rst_viol_cnt", {224'd0, lpi_violation_count}, 256'd0);
        @(posedge axi_aclk); #1;
        axi_resetn = 1'b1;
        @(posedge axi_aclk); #1;

        // Announcement dropped, partner sequence SLEEP x3, LPI x6, WAKE x4, ACTIVE
        clear_q();
        s_tdata = a1; s_tlast = 1'b0; s_tvalid = 1'b1; s_tstrb = '1; s_tuser = '0;
        @(negedge axi_aclk);
        check("ann_b1_ready", {255'd0, s_tready}, 256'd1);
        check("ann_b1_mvalid", {255'd0, m_tvalid}, 256'd0);
        @(posedge axi_aclk); #1;
        s_tdata = a2; s_tlast = 1'b1;
        @(negedge axi_aclk);
        check("ann_b2_ready", {255'd0, s_tready}, 256'd1);
        check("ann_b2_mvalid", {255'd0, m_tvalid}, 256'd0);
        @(posedge axi_aclk); #1;
        s_tvalid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge axi_aclk);
            exp_ps = (k < 3) ? 2'd1 : (k < 9) ? 2'd2 : (k < 13) ? 2'd3 : 2'd0;
            check($sformatf("ann_ps_%0d", k), {254'd0, partner_state}, {254'd0, exp_ps});
            if (k == 0) check("ann_pulse_hi", {255'd0, announce_pulse}, 256'd1);
            if (k == 1) check("ann_pulse_lo", {255'd0, announce_pulse}, 256'd0);
            @(posedge axi_aclk); #1;
        end
        check("ann_count", {224'd0, announce_count}, 256'd1);
        check("ann_no_output", mq_d.size(), 256'd0);
        check("ann_viol", {224'd0, lpi_violation_count}, 256'd0);

        // Near-miss magic: both beats forwarded bit-exact
        clear_q();
        send(a1, 128'h1234_5678, 1'b0);
        send(nm2, 128'h9abc, 1'b1);
        check("nm_nbeats", mq_d.size(), 256'd2);
        check_beat("nm_b0", 0, a1, 1'b0);
        check_beat("nm_b1", 1, nm2, 1'b1);
        if (mq_u.size() > 0) begin
            check("nm_b0_user", mq_u[0], 256'h1234_5678);
            check("nm_b0_strb", mq_s[0], 256'hffff_ffff);
        end
        check("nm_ann_count", {224'd0, announce_count}, 256'd1);

        // Normal 3-beat packet with m_tready toggling
        clear_q();
        tog_en = 1'b1;
        send(p1, 128'h1, 1'b0);
        send(p2, 128'h2, 1'b0);
        send(p3, 128'h3, 1'b1);
        tog_en = 1'b0;
        @(posedge axi_aclk); #2;
        m_tready = 1'b1;
        check("pkt_nbeats", mq_d.size(), 256'd3);
        check_beat("pkt_b0", 0, p1, 1'b0);
        check_beat("pkt_b1", 1, p2, 1'b0);
        check_beat("pkt_b2", 2, p3, 1'b1);
        check("pkt_ann_count", {224'd0, announce_count}, 256'd1);

        // Held beat stays stable across idle gap and backpressure
        @(posedge axi_aclk); #1;
        clear_q();
        m_tready = 1'b0;
        send(a1, 128'h55, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge axi_aclk);
            check($sformatf("hold_idle_mvalid_%0d", k), {255'd0, m_tvalid}, 256'd0);
            check($sformatf("hold_idle_sready_%0d", k), {255'd0, s_tready}, 256'd0);
            @(posedge axi_aclk); #1;
        end
        s_tdata = nm2; s_tuser = 128'h66; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge axi_aclk);
            check($sformatf("hold_bp_mvalid_%0d", k), {255'd0, m_tvalid}, 256'd1);
            check($sformatf("hold_bp_mdata_%0d", k), m_tdata, a1);
            check($sformatf("hold_bp_sready_%0d", k), {255'd0, s_tready}, 256'd0);
            @(posedge axi_aclk); #1;
        end
        m_tready = 1'b1;
        @(negedge axi_aclk);
        check("hold_rel_sready", {255'd0, s_tready}, 256'd0);
        check("hold_rel_mdata", m_tdata, a1);
        @(posedge axi_aclk); #1;
        @(negedge axi_aclk);
        check("hold_b2_sready", {255'd0, s_tready}, 256'd1);
        check("hold_b2_mdata", m_tdata, nm2);
        @(posedge axi_aclk); #1;
        s_tvalid = 1'b0;
        check("hold_nbeats", mq_d.size(), 256'd2);
        check_beat("hold_b0", 0, a1, 1'b0);
        check_beat("hold_b1", 1, nm2, 1'b1);

        // Re-announcement during LPI restarts SLEEP; packet in SLEEP counts as violations
        clear_q();
        send(a1, 128'h0, 1'b0);
        send(a2, 128'h0, 1'b1);
        w = 0;
        forever begin
            @(negedge axi_aclk);
            if (partner_state == 2'd2) break;
            w++;
            if (w > 20) begin
                check("re_wait_lpi", {254'd0, partner_state}, 256'd2);
                break;
            end
        end
        @(posedge axi_aclk); #1;
        send(a1, 128'h0, 1'b0);
        send(a2, 128'h0, 1'b1);
        @(negedge axi_aclk);
        check("re_ps_sleep", {254'd0, partner_state}, 256'd1);
        check("re_pulse", {255'd0, announce_pulse}, 256'd1);
        @(posedge axi_aclk); #1;
        send(p1, 128'h7, 1'b0);
        send(p2, 128'h8, 1'b0);
        send(p3, 128'h9, 1'b1);
        check("re_ann_count", {224'd0, announce_count}, 256'd3);
        check("re_viol_count", {224'd0, lpi_violation_count}, 256'd3);
        check("re_nbeats", mq_d.size(), 256'd3);
        check_beat("re_b0", 0, p1, 1'b0);

        // Reset while holding a candidate beat
        repeat (16) @(posedge axi_aclk);
        #1;
        clear_q();
        m_tready = 1'b0;
        send(a1, 128'h0, 1'b0);
        s_tdata = nm2; s_tlast = 1'b1; s_tvalid = 1'b1;
        @(negedge axi_aclk);
        check("hrst_pre_mvalid", {255'd0, m_tvalid}, 256'd1);
        #2;
        axi_resetn = 1'b0;
        #1;
        check("hrst_mvalid", {255'd0, m_tvalid}, 256'd0);
        check("hrst_sready", {255'd0, s_tready}, 256'd0);
        check("hrst_ann_count", {224'd0, announce_count}, 256'd0);
        check("hrst_viol_count", {224'd0, lpi_violation_count}, 256'd0);
        check("hrst_pstate", {254'd0, partner_state}, 256'd0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        m_tready = 1'b1;
        @(posedge axi_aclk); #1;
        clear_q();
        send(p1, 128'hA, 1'b0);
        send(p3, 128'hB, 1'b1);
        check("hrst_nbeats", mq_d.size(), 256'd2);
        check_beat("hrst_b0", 0, p1, 1'b0);
        check_beat("hrst_b1", 1, p3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
